// File: rtl/dynamixel_write_scheduler.sv
// dynamixel_write_scheduler
// Arbitrates torque-enable and goal-position packets into the sync-write
// engine. Torque always wins. A start handshake is supervised with a
// timeout, and an idle gap follows every packet. Position updates coalesce
// per channel, and requests that arrive while busy are held until served.
module dynamixel_write_scheduler #(
    parameter int clock_frequency = 12000000,
    parameter int position_period = clock_frequency / 50,
    parameter int gap_clocks      = 48,
    parameter int start_timeout   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        channel_changed,
    input  logic [3:0]  channel_index,
    input  logic [10:0] channel_value,
    input  logic        torque_request,
    input  logic        torque_enable,
    input  logic        writer_sending,
    output logic        writer_send,
    output logic [15:0] address,
    output logic [15:0] data_len,
    output logic [31:0] value1,
    output logic [31:0] value2,
    output logic [31:0] value3,
    output logic [31:0] value4,
    output logic        torque_state,
    output logic        busy,
    output logic        error
);

    localparam int PW      = (position_period > 1) ? $clog2(position_period) : 1;
    localparam int CNT_MAX = (gap_clocks > start_timeout) ? gap_clocks : start_timeout;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [15:0] TORQUE_ADDR = 16'd64;
    localparam logic [15:0] TORQUE_LEN  = 16'd1;
    localparam logic [15:0] POS_ADDR    = 16'd116;
    localparam logic [15:0] POS_LEN     = 16'd4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t      state;
    logic [10:0] pos0, pos1, pos2, pos3;
    logic        pos_dirty;
    logic        position_due;
    logic        torque_pending;
    logic        torque_value;
    logic        pkt_is_torque;
    logic        pkt_torque_value;
    logic [PW-1:0] period_cnt;
    logic [CW-1:0] cnt;
    logic        period_wrap;
    logic        chan_hit;

    // Only channels 0..3 drive servos; higher indices are ignored.
    assign chan_hit    = channel_changed && (channel_index[3:2] == 2'b00);
    assign period_wrap = (period_cnt == PW'(position_period - 1));
    assign busy        = (state != IDLE);

    // Latest raw channel value per servo; positions coalesce here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos0 <= '0;
            pos1 <= '0;
            pos2 <= '0;
            pos3 <= '0;
        end else if (chan_hit) begin
            case (channel_index[1:0])
                2'd0:    pos0 <= channel_value;
                2'd1:    pos1 <= channel_value;
                2'd2:    pos2 <= channel_value;
                default: pos3 <= channel_value;
            endcase
        end
    end

    // Free-running period counter that opens a position-packet opportunity.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (period_wrap) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // Arbitration FSM with request flags and registered writer outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            writer_send      <= 1'b0;
            address          <= '0;
            data_len         <= '0;
            value1           <= '0;
            value2           <= '0;
            value3           <= '0;
            value4           <= '0;
            torque_state     <= 1'b0;
            error            <= 1'b0;
            pos_dirty        <= 1'b0;
            position_due     <= 1'b0;
            torque_pending   <= 1'b0;
            torque_value     <= 1'b0;
            pkt_is_torque    <= 1'b0;
            pkt_torque_value <= 1'b0;
            cnt              <= '0;
        end else begin
            writer_send <= 1'b0;
            // Capture happens every cycle. The arbitration branch below only
            // clears a flag when no fresh request of that source coincides.
            if (torque_request) begin
                torque_pending <= 1'b1;
                torque_value   <= torque_enable;
            end
            if (chan_hit) begin
                pos_dirty <= 1'b1;
            end
            if (period_wrap) begin
                position_due <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (torque_pending) begin
                        state            <= ISSUE;
                        writer_send      <= 1'b1;
                        address          <= TORQUE_ADDR;
                        data_len         <= TORQUE_LEN;
                        value1           <= {31'b0, torque_value};
                        value2           <= {31'b0, torque_value};
                        value3           <= {31'b0, torque_value};
                        value4           <= {31'b0, torque_value};
                        pkt_is_torque    <= 1'b1;
                        pkt_torque_value <= torque_value;
                        if (!torque_request) begin
                            torque_pending <= 1'b0;
                        end
                    end else if (pos_dirty && position_due) begin
                        state         <= ISSUE;
                        writer_send   <= 1'b1;
                        address       <= POS_ADDR;
                        data_len      <= POS_LEN;
                        value1        <= {20'b0, pos0, 1'b0};
                        value2        <= {20'b0, pos1, 1'b0};
                        value3        <= {20'b0, pos2, 1'b0};
                        value4        <= {20'b0, pos3, 1'b0};
                        pkt_is_torque <= 1'b0;
                        if (!chan_hit) begin
                            pos_dirty <= 1'b0;
                        end
                        if (!period_wrap) begin
                            position_due <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_START;
                    cnt   <= '0;
                end
                WAIT_START: begin
                    if (writer_sending) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CW'(start_timeout - 1)) begin
                        // Writer never acknowledged; drop the packet and move on.
                        error <= 1'b1;
                        state <= GAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!writer_sending) begin
                        if (pkt_is_torque) begin
                            torque_state <= pkt_torque_value;
                        end
                        state <= GAP;
                        cnt   <= '0;
                    end
                end
                GAP: begin
                    if (cnt == CW'(gap_clocks - 1)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dynamixel_write_scheduler.sv
// Directed bench for dynamixel_write_scheduler with a short position period.
module tb_dynamixel_write_scheduler;

    localparam int PERIOD = 300;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        channel_changed = 1'b0;
    logic [3:0]  channel_index = '0;
    logic [10:0] channel_value = '0;
    logic        torque_request = 1'b0;
    logic        torque_enable = 1'b0;
    logic        writer_sending = 1'b0;
    logic        writer_send;
    logic [15:0] address;
    logic [15:0] data_len;
    logic [31:0] value1, value2, value3, value4;
    logic        torque_state;
    logic        busy;
    logic        error;

    int total = 0;
    int bad = 0;
    int send_cnt = 0;

    dynamixel_write_scheduler #(
        .clock_frequency(12000000),
        .position_period(PERIOD),
        .gap_clocks(48),
        .start_timeout(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .channel_changed(channel_changed),
        .channel_index(channel_index),
        .channel_value(channel_value),
        .torque_request(torque_request),
        .torque_enable(torque_enable),
        .writer_sending(writer_sending),
        .writer_send(writer_send),
        .address(address),
        .data_len(data_len),
        .value1(value1),
        .value2(value2),
        .value3(value3),
        .value4(value4),
        .torque_state(torque_state),
        .busy(busy),
        .error(error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (writer_send) send_cnt++;
    end

    // Returns at the negedge where writer_send is seen high, or ok=0 on timeout.
    task automatic wait_send(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clock);
            if (writer_send) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Writer behaviour after an ISSUE cycle, then let the gap run out.
    task automatic serve(input int delay, input int hold);
        repeat (delay) @(negedge clock);
        writer_sending = 1'b1;
        repeat (hold) @(negedge clock);
        writer_sending = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!busy) break;
        end
    endtask

    task automatic set_channel(input logic [3:0] idx, input logic [10:0] val);
        channel_changed = 1'b1;
        channel_index   = idx;
        channel_value   = val;
        @(negedge clock);
        channel_changed = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        total++;
        if ({writer_send, busy, error, torque_state} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {writer_send, busy, error, torque_state});
        end
        total++;
        if ({address, data_len, value1, value2, value3, value4} !== '0) begin
            bad++; $display("FAIL reset_data addr=%0d len=%0d v1=%0d want all 0", address, data_len, value1);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_torque_basic;
        torque_enable  = 1'b1;
        torque_request = 1'b1;
        @(negedge clock);
        torque_request = 1'b0;
        total++;
        if (writer_send !== 1'b0) begin bad++; $display("FAIL t1_send_early got=%b want=0", writer_send); end
        @(negedge clock);
        total++;
        if (writer_send !== 1'b1) begin bad++; $display("FAIL t1_send_latency got=%b want=1", writer_send); end
        total++;
        if (address !== 16'd64 || data_len !== 16'd1) begin
            bad++; $display("FAIL t1_hdr addr=%0d len=%0d want 64/1", address, data_len);
        end
        total++;
        if (value1 !== 32'd1 || value2 !== 32'd1 || value3 !== 32'd1 || value4 !== 32'd1) begin
            bad++; $display("FAIL t1_values got=%0d/%0d/%0d/%0d want 1/1/1/1", value1, value2, value3, value4);
        end
        @(negedge clock);
        total++;
        if (writer_send !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL t1_pulse send=%b busy=%b want 0/1", writer_send, busy);
        end
        @(negedge clock);
        writer_sending = 1'b1;
        repeat (100) @(negedge clock);
        total++;
        if (torque_state !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL t1_during ts=%b busy=%b want 0/1", torque_state, busy);
        end
        writer_sending = 1'b0;
        @(negedge clock);
        total++;
        if (torque_state !== 1'b1) begin bad++; $display("FAIL t1_torque_state got=%b want=1", torque_state); end
        repeat (47) @(negedge clock);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL t1_gap_short busy=%b want=1", busy); end
        @(negedge clock);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL t1_gap_end busy=%b want=0", busy); end
        total++;
        if (send_cnt !== 1) begin bad++; $display("FAIL t1_send_count got=%0d want=1", send_cnt); end
    endtask

    task automatic test_position;
        bit ok;
        int snap;
        set_channel(4'd0, 11'd1000);
        set_channel(4'd1, 11'd172);
        set_channel(4'd2, 11'd1811);
        set_channel(4'd3, 11'd2047);
        wait_send(2 * PERIOD + 10, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL t2_issue timeout got=0 want=1"); end
        total++;
        if (address !== 16'd116 || data_len !== 16'd4) begin
            bad++; $display("FAIL t2_hdr addr=%0d len=%0d want 116/4", address, data_len);
        end
        total++;
        if (value1 !== 32'd2000 || value2 !== 32'd344 || value3 !== 32'd3622 || value4 !== 32'd4094) begin
            bad++; $display("FAIL t2_values got=%0d/%0d/%0d/%0d want 2000/344/3622/4094", value1, value2, value3, value4);
        end
        serve(2, 5);
        snap = send_cnt;
        repeat (2 * PERIOD + 10) @(negedge clock);
        total++;
        if (send_cnt !== snap) begin bad++; $display("FAIL t2_no_repeat got=%0d want=%0d", send_cnt, snap); end
    endtask

    task automatic test_arbitration;
        bit ok;
        torque_enable   = 1'b0;
        torque_request  = 1'b1;
        channel_changed = 1'b1;
        channel_index   = 4'd2;
        channel_value   = 11'd100;
        @(negedge clock);
        torque_request  = 1'b0;
        channel_changed = 1'b0;
        wait_send(10, ok);
        total++;
        if (!ok || address !== 16'd64 || value1 !== 32'd0) begin
            bad++; $display("FAIL t3_first ok=%b addr=%0d v1=%0d want 1/64/0", ok, address, value1);
        end
        serve(2, 5);
        wait_send(5, ok);
        total++;
        if (!ok || address !== 16'd116) begin
            bad++; $display("FAIL t3_second ok=%b addr=%0d want 1/116", ok, address);
        end
        total++;
        if (value1 !== 32'd2000 || value3 !== 32'd200) begin
            bad++; $display("FAIL t3_values v1=%0d v3=%0d want 2000/200", value1, value3);
        end
        serve(2, 5);
        total++;
        if (torque_state !== 1'b0) begin bad++; $display("FAIL t3_torque_state got=%b want=0", torque_state); end
    endtask

    task automatic test_timeout;
        bit ok;
        torque_enable  = 1'b1;
        torque_request = 1'b1;
        @(negedge clock);
        torque_request = 1'b0;
        wait_send(10, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL t4_issue timeout got=0 want=1"); end
        repeat (16) @(negedge clock);
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL t4_error_early got=%b want=0", error); end
        @(negedge clock);
        total++;
        if (error !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL t4_error_set err=%b busy=%b want 1/1", error, busy);
        end
        repeat (48) @(negedge clock);
        total++;
        if (busy !== 1'b0 || torque_state !== 1'b0) begin
            bad++; $display("FAIL t4_gap_idle busy=%b ts=%b want 0/0", busy, torque_state);
        end
        torque_request = 1'b1;
        @(negedge clock);
        torque_request = 1'b0;
        wait_send(10, ok);
        total++;
        if (!ok || address !== 16'd64) begin
            bad++; $display("FAIL t4_retry ok=%b addr=%0d want 1/64", ok, address);
        end
        serve(2, 5);
        total++;
        if (error !== 1'b1 || torque_state !== 1'b1) begin
            bad++; $display("FAIL t4_sticky err=%b ts=%b want 1/1", error, torque_state);
        end
    endtask

    task automatic test_same_cycle_change;
        bit ok;
        int snap;
        set_channel(4'd1, 11'd100);
        wait_send(2 * PERIOD + 10, ok);
        channel_changed = 1'b1;
        channel_index   = 4'd0;
        channel_value   = 11'd500;
        total++;
        if (!ok || address !== 16'd116) begin
            bad++; $display("FAIL t5_issue ok=%b addr=%0d want 1/116", ok, address);
        end
        total++;
        if (value1 !== 32'd2000 || value2 !== 32'd200 || value3 !== 32'd200 || value4 !== 32'd4094) begin
            bad++; $display("FAIL t5_old got=%0d/%0d/%0d/%0d want 2000/200/200/4094", value1, value2, value3, value4);
        end
        @(negedge clock);
        channel_changed = 1'b0;
        serve(1, 5);
        wait_send(2 * PERIOD + 10, ok);
        total++;
        if (!ok || value1 !== 32'd1000 || value2 !== 32'd200) begin
            bad++; $display("FAIL t5_new ok=%b v1=%0d v2=%0d want 1/1000/200", ok, value1, value2);
        end
        serve(2, 5);
        set_channel(4'd7, 11'd5);
        snap = send_cnt;
        repeat (2 * PERIOD + 10) @(negedge clock);
        total++;
        if (send_cnt !== snap || value1 !== 32'd1000) begin
            bad++; $display("FAIL t5_idx7 sends=%0d v1=%0d want %0d/1000", send_cnt, value1, snap);
        end
    endtask

    task automatic test_reset_mid_packet;
        bit ok;
        int snap;
        torque_enable  = 1'b1;
        torque_request = 1'b1;
        @(negedge clock);
        torque_request = 1'b0;
        wait_send(10, ok);
        repeat (2) @(negedge clock);
        writer_sending = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #1;
        total++;
        if (!ok || {writer_send, busy, error, torque_state} !== 4'b0) begin
            bad++; $display("FAIL t6_flags ok=%b got=%b want 0000", ok, {writer_send, busy, error, torque_state});
        end
        total++;
        if ({address, data_len, value1, value2, value3, value4} !== '0) begin
            bad++; $display("FAIL t6_data addr=%0d len=%0d v1=%0d want all 0", address, data_len, value1);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        writer_sending = 1'b0;
        snap = send_cnt;
        repeat (2 * PERIOD + 10) @(negedge clock);
        total++;
        if (send_cnt !== snap || busy !== 1'b0) begin
            bad++; $display("FAIL t6_quiet sends=%0d busy=%b want %0d/0", send_cnt, busy, snap);
        end
    endtask

    initial begin
        test_reset();
        test_torque_basic();
        test_position();
        test_arbitration();
        test_timeout();
        test_same_cycle_change();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
